// File: rtl/button_event_arbiter.sv
// button_event_arbiter: turns debounced button levels into PRESS/RELEASE/LONG/REPEAT events on one round-robin stream
module button_event_arbiter #(
    parameter int N_BTN       = 4,
    parameter int CLKS_LONG   = 25_000_000,
    parameter int CLKS_REPEAT = 5_000_000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_BTN-1:0]         i_btn,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [$clog2(N_BTN)-1:0] o_btn_id,
    output logic [1:0]               o_event,
    output logic [N_BTN-1:0]         o_held,
    output logic                     o_overflow
);
    localparam int IW   = $clog2(N_BTN);
    localparam int SW   = IW + 1;
    localparam int CMAX = CLKS_LONG > CLKS_REPEAT ? CLKS_LONG : CLKS_REPEAT;
    localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] LONG_END = CW'(CLKS_LONG - 1);
    localparam logic [CW-1:0] REP_END  = CW'(CLKS_REPEAT - 1);
    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_LONG    = 2;
    localparam int EV_REPEAT  = 3;

    typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} state_t;

    logic [N_BTN-1:0][1:0]    state_q, state_d;
    logic [N_BTN-1:0][CW-1:0] cnt_q, cnt_d;
    logic [N_BTN-1:0][3:0]    pend_q, pend_d, set;
    logic [N_BTN-1:0]         prev_q, held_q, held_d;
    logic                     armed_q;
    logic [IW-1:0]            rr_q, rr_d, gnt_id, id_q, id_d;
    logic [1:0]               gnt_ev, ev_q, ev_d;
    logic                     gnt_found, load, clr;
    logic                     valid_q, valid_d, ovf_q, ovf_d;
    logic [SW-1:0]            scan;

    // Per-button FSM: edge detect, long-press and auto-repeat timing; release always wins
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        set     = '0;
        held_d  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (armed_q) begin
                if (state_q[i] == S_IDLE) begin
                    if (i_btn[i] && !prev_q[i]) begin
                        set[i][EV_PRESS] = 1'b1;
                        cnt_d[i]         = '0;
                        state_d[i]       = S_PRESSED;
                    end
                end else if (!i_btn[i]) begin
                    set[i][EV_RELEASE] = 1'b1;
                    state_d[i]         = S_IDLE;
                end else if (state_q[i] == S_PRESSED && cnt_q[i] == LONG_END) begin
                    set[i][EV_LONG] = 1'b1;
                    cnt_d[i]        = '0;
                    state_d[i]      = S_HELD;
                end else if (state_q[i] == S_HELD && cnt_q[i] == REP_END) begin
                    set[i][EV_REPEAT] = 1'b1;
                    cnt_d[i]          = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
            held_d[i] = state_d[i] != S_IDLE;
        end
    end

    // Round-robin grant, pending-flag bookkeeping and output register load
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan      = '0;
        clr       = 1'b0;
        for (int k = 0; k < N_BTN; k++) begin
            scan = SW'(rr_q) + SW'(k);
            scan = scan >= SW'(N_BTN) ? scan - SW'(N_BTN) : scan;
            if (!gnt_found && pend_q[scan[IW-1:0]] != 4'b0) begin
                gnt_found = 1'b1;
                gnt_id    = scan[IW-1:0];
            end
        end
        gnt_ev = pend_q[gnt_id][EV_PRESS]  ? 2'd0 :
                 pend_q[gnt_id][EV_LONG]   ? 2'd2 :
                 pend_q[gnt_id][EV_REPEAT] ? 2'd3 : 2'd1;
        load   = !valid_q || i_ready;
        ovf_d  = ovf_q;
        pend_d = pend_q;
        for (int i = 0; i < N_BTN; i++) begin
            for (int e = 0; e < 4; e++) begin
                clr          = load && gnt_found && gnt_id == IW'(i) && gnt_ev == 2'(e);
                pend_d[i][e] = set[i][e] | (pend_q[i][e] & ~clr);
                ovf_d        = ovf_d | (set[i][e] & pend_q[i][e] & ~clr);
            end
        end
        valid_d = load ? gnt_found : valid_q;
        id_d    = load && gnt_found ? gnt_id : id_q;
        ev_d    = load && gnt_found ? gnt_ev : ev_q;
        rr_d    = !(load && gnt_found) ? rr_q :
                  gnt_id == IW'(N_BTN - 1) ? '0 : gnt_id + IW'(1);
    end

    // State registers; the first edge after reset only captures button levels
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            armed_q <= 1'b0;
            prev_q  <= '0;
            state_q <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
            held_q  <= '0;
            rr_q    <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            ev_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            prev_q  <= i_btn;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            held_q  <= held_d;
            rr_q    <= rr_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            ev_q    <= ev_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_btn_id   = id_q;
    assign o_event    = ev_q;
    assign o_held     = held_q;
    assign o_overflow = ovf_q;
endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: directed and randomized checks of button_event_arbiter against a behavioural model
module tb_button_event_arbiter;
    localparam int N   = 4;
    localparam int L   = 20;
    localparam int R   = 5;
    localparam int PRS = 0;
    localparam int REL = 1;
    localparam int LNG = 2;
    localparam int REP = 3;

    typedef struct { int c; int id; int ev; } evt_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         ready = 1'b1;
    logic [N-1:0] btn   = '0;
    logic         valid, ovf;
    logic [1:0]   id, ev;
    logic [N-1:0] held;
    logic [9:0]   dvec;
    int           errors = 0;
    int           checks = 0;
    int           cyc    = 0;
    evt_t         log_q[$];

    always #5 clk = ~clk;
    assign dvec = {valid, id, ev, held, ovf};

    button_event_arbiter #(.N_BTN(N), .CLKS_LONG(L), .CLKS_REPEAT(R)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn), .i_ready(ready),
        .o_valid(valid), .o_btn_id(id), .o_event(ev), .o_held(held), .o_overflow(ovf)
    );

    // Events the consumer actually took, stamped with the index of the accepting edge
    always @(posedge clk) begin
        if (rst_n && valid && ready) log_q.push_back('{cyc, int'(id), int'(ev)});
        cyc++;
    end

    // Behavioural model: time-since-press arithmetic, one flag per event type, rotating search
    bit           m_armed, m_valid, m_ovf, m_load, m_clr;
    bit [N-1:0]   m_prev, m_on;
    bit [3:0]     m_pend [N];
    bit [3:0]     m_set [N];
    int           m_t [N];
    int           m_id, m_ev, m_rr, m_g, m_ge;
    int           prio [4] = '{0, 2, 3, 1};

    always @(posedge clk) begin
        if (!rst_n) begin
            m_armed = 0; m_valid = 0; m_ovf = 0; m_prev = '0; m_on = '0;
            m_id = 0; m_ev = 0; m_rr = 0;
            for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_t[i] = 0; end
        end else begin
            m_load = !m_valid || ready;
            m_g = -1;
            m_ge = 0;
            for (int k = 0; k < N; k++)
                if (m_g < 0 && m_pend[(m_rr + k) % N] != 0) m_g = (m_rr + k) % N;
            if (m_g >= 0)
                for (int p = 3; p >= 0; p--) if (m_pend[m_g][prio[p]]) m_ge = prio[p];
            for (int i = 0; i < N; i++) begin
                m_set[i] = 0;
                if (m_armed) begin
                    if (!m_on[i] && btn[i] && !m_prev[i]) begin
                        m_set[i][PRS] = 1; m_on[i] = 1; m_t[i] = 0;
                    end else if (m_on[i] && !btn[i]) begin
                        m_set[i][REL] = 1; m_on[i] = 0;
                    end else if (m_on[i]) begin
                        m_t[i]++;
                        if (m_t[i] == L) m_set[i][LNG] = 1;
                        else if (m_t[i] > L && (m_t[i] - L) % R == 0) m_set[i][REP] = 1;
                    end
                end
            end
            m_prev = btn;
            m_armed = 1;
            for (int i = 0; i < N; i++)
                for (int e = 0; e < 4; e++) begin
                    m_clr = m_load && m_g == i && m_ge == e;
                    if (m_set[i][e]) begin
                        if (m_pend[i][e] && !m_clr) m_ovf = 1;
                        m_pend[i][e] = 1;
                    end else if (m_clr) m_pend[i][e] = 0;
                end
            if (m_load) begin
                if (m_g >= 0) begin m_valid = 1; m_id = m_g; m_ev = m_ge; m_rr = (m_g + 1) % N; end
                else m_valid = 0;
            end
        end
    end

    function automatic logic [9:0] mvec();
        return {m_valid, 2'(m_id), 2'(m_ev), m_on, m_ovf};
    endfunction

    task automatic apply_reset(input logic [N-1:0] b);
        btn = b;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        log_q.delete();
    endtask

    task automatic test_reset();
        btn = '0; ready = 1'b1; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dvec !== 10'b0) begin errors++; $display("FAIL reset_outputs: got %b want %b", dvec, 10'b0); end
        rst_n = 1'b1;
        btn = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b0 || held !== 4'b0) begin
                errors++; $display("FAIL arm_no_event k=%0d: got valid=%b held=%b want 0/0000", k, valid, held);
            end
            checks++;
            if (dvec !== mvec()) begin errors++; $display("FAIL model_reset k=%0d: got %b want %b", k, dvec, mvec()); end
        end
        btn = '0;
        @(negedge clk);
    endtask

    task automatic test_press_release();
        apply_reset('0);
        btn = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) btn = '0;
            @(negedge clk);
            checks++;
            if (dvec !== mvec()) begin errors++; $display("FAIL model_press k=%0d: got %b want %b", k, dvec, mvec()); end
        end
        checks++;
        if (log_q.size() != 2 || log_q[0].id != 0 || log_q[0].ev != PRS || log_q[1].id != 0 || log_q[1].ev != REL) begin
            errors++; $display("FAIL press_release_seq: got %0d events want PRESS0,RELEASE0", log_q.size());
        end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL press_overflow: got %b want 0", ovf); end
    endtask

    task automatic test_long_repeat();
        int c0;
        int offs [7] = '{2, 22, 27, 32, 37, 42, 43};
        int evs [7]  = '{PRS, LNG, REP, REP, REP, REP, REL};
        apply_reset('0);
        c0 = cyc;
        btn = 4'b0010;
        for (int k = 0; k < 46; k++) begin
            if (k == 41) btn = '0;
            @(negedge clk);
            checks++;
            if (dvec !== mvec()) begin errors++; $display("FAIL model_long k=%0d: got %b want %b", k, dvec, mvec()); end
            if (k <= 40) begin
                checks++;
                if (held[1] !== 1'b1) begin errors++; $display("FAIL held1 k=%0d: got %b want 1", k, held[1]); end
            end
        end
        checks++;
        if (log_q.size() != 7) begin errors++; $display("FAIL long_count: got %0d want 7", log_q.size()); end
        else
            for (int j = 0; j < 7; j++) begin
                checks++;
                if (log_q[j].c - c0 != offs[j] || log_q[j].ev != evs[j] || log_q[j].id != 1) begin
                    errors++;
                    $display("FAIL long_evt%0d: got t=%0d ev=%0d id=%0d want t=%0d ev=%0d id=1",
                             j, log_q[j].c - c0, log_q[j].ev, log_q[j].id, offs[j], evs[j]);
                end
            end
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] pat [6] = '{4'b1111, 4'b0000, 4'b0010, 4'b0000, 4'b1111, 4'b0000};
        int len [6] = '{8, 8, 2, 6, 6, 6};
        int ids [18] = '{0,1,2,3, 0,1,2,3, 1,1, 2,3,0,1, 2,3,0,1};
        int evs [18] = '{0,0,0,0, 1,1,1,1, 0,1, 0,0,0,0, 1,1,1,1};
        apply_reset('0);
        for (int p = 0; p < 6; p++) begin
            btn = pat[p];
            for (int k = 0; k < len[p]; k++) begin
                @(negedge clk);
                checks++;
                if (dvec !== mvec()) begin errors++; $display("FAIL model_simul p=%0d k=%0d: got %b want %b", p, k, dvec, mvec()); end
            end
        end
        checks++;
        if (log_q.size() != 18) begin errors++; $display("FAIL simul_count: got %0d want 18", log_q.size()); end
        else
            for (int j = 0; j < 18; j++) begin
                checks++;
                if (log_q[j].id != ids[j] || log_q[j].ev != evs[j]) begin
                    errors++; $display("FAIL simul_evt%0d: got id=%0d ev=%0d want id=%0d ev=%0d", j, log_q[j].id, log_q[j].ev, ids[j], evs[j]);
                end
            end
    endtask

    task automatic test_backpressure();
        apply_reset('0);
        ready = 1'b0;
        btn = 4'b0100;
        @(negedge clk);
        btn = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({valid, id, ev} !== 5'b1_10_00) begin
                errors++; $display("FAIL stall_hold k=%0d: got v=%b id=%0d ev=%0d want v=1 id=2 ev=0", k, valid, id, ev);
            end
        end
        ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({valid, id, ev} !== 5'b1_10_01) begin
            errors++; $display("FAIL stall_release: got v=%b id=%0d ev=%0d want v=1 id=2 ev=1", valid, id, ev);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got valid=%b want 0", valid); end
        checks++;
        if (dvec !== mvec()) begin errors++; $display("FAIL model_stall: got %b want %b", dvec, mvec()); end
    endtask

    task automatic test_overflow();
        logic [N-1:0] pat [6] = '{4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000};
        apply_reset('0);
        ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            btn = pat[k];
            @(negedge clk);
            checks++;
            if (ovf !== 1'(k >= 4)) begin errors++; $display("FAIL ovf_set k=%0d: got %b want %b", k, ovf, k >= 4); end
            checks++;
            if (dvec !== mvec()) begin errors++; $display("FAIL model_ovf k=%0d: got %b want %b", k, dvec, mvec()); end
        end
        ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky k=%0d: got %b want 1", k, ovf); end
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_reset: got %b want 0", ovf); end
        @(negedge clk);
    endtask

    task automatic test_held_through_reset();
        int rels;
        apply_reset(4'b0010);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b0) begin errors++; $display("FAIL held_reset_quiet k=%0d: got valid=%b want 0", k, valid); end
        end
        btn = '0;
        repeat (3) @(negedge clk);
        btn = 4'b0010;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checks++;
            if (dvec !== mvec()) begin errors++; $display("FAIL model_heldrst k=%0d: got %b want %b", k, dvec, mvec()); end
        end
        rels = 0;
        foreach (log_q[j]) if (log_q[j].ev == REL) rels++;
        checks++;
        if (log_q.size() < 1 || log_q[0].id != 1 || log_q[0].ev != PRS || rels != 0) begin
            errors++; $display("FAIL held_reset_seq: got %0d events %0d releases want first PRESS1 and no release", log_q.size(), rels);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || held !== 4'b0) begin
            errors++; $display("FAIL reset_mid_held: got valid=%b held=%b want 0/0000", valid, held);
        end
        rst_n = 1'b1;
        btn = '0;
        @(negedge clk);
    endtask

    task automatic test_random();
        apply_reset('0);
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, i < 2 ? 29 : 5) == 0) btn[i] = ~btn[i];
            ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            checks++;
            if (dvec !== mvec()) begin errors++; $display("FAIL model_random k=%0d: got %b want %b", k, dvec, mvec()); end
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_long_repeat();
        test_simultaneous();
        test_backpressure();
        test_overflow();
        test_held_through_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
